// File: rtl/add_accum.sv
// add_accum: registered add-and-accumulate block.
//
// Each accepted beat adds two WIDTH-bit unsigned operands. COUNT consecutive
// beats are summed into one frame total. The total is presented on a
// valid/ready output and held until the consumer takes it. OUT_W is sized so
// that a full frame of maximum operands cannot overflow.
//
// Optional feature macro: ADD_CLR_EN. When defined, the block gains a `clr`
// input that aborts the current frame or drops a pending sum.
//
// Parameters:
//   WIDTH  operand width in bits (>= 1)
//   COUNT  beats per frame (>= 1)
//   OUT_W  derived sum width, WIDTH+1+$clog2(COUNT), not overridable
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   clr        synchronous frame abort (only with ADD_CLR_EN)
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle
//   a, b       unsigned operands
//   out_valid  frame sum present on c
//   out_ready  consumer takes the sum this cycle
//   c          frame sum, unsigned
module add_accum #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  localparam int OUT_W = WIDTH + 1 + $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ADD_CLR_EN
  input  logic             clr,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] c
);

  // The counter needs at least one bit even when COUNT is 1.
  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(COUNT - 1);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] beat_sum;
  logic [OUT_W-1:0] acc_base;

  // Operands are zero-extended to the full sum width so the addition never wraps.
  assign beat_sum = OUT_W'(a) + OUT_W'(b);

  // The first beat of a frame starts from zero. Until then, acc keeps the
  // previous total visible on c.
  assign acc_base = (cnt_q == '0) ? '0 : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = acc_base + beat_sum;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // Leaving HOLD takes the whole cycle. The next beat is accepted only
        // from ACC, so there is no same-cycle bypass.
        if (out_ready) begin
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
`ifdef ADD_CLR_EN
    // clr overrides any handshake. A beat offered in this cycle is lost, and a
    // pending sum is dropped without a handshake.
    if (clr) begin
      state_d = ACC;
      cnt_d   = '0;
      acc_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign c         = acc_q;

endmodule

// File: tb/tb_add_accum.sv
// tb_add_accum: randomized scoreboard bench for add_accum.
//
// Two instances share the same stimulus: COUNT=4 and COUNT=1, both with
// WIDTH=8. The driver applies one cycle of inputs. It then updates a
// frame-level reference model and pushes each completed frame sum into a
// per-instance queue. A separate monitor checks the outputs on the falling
// edge and pops a sum when the output handshake completes. If ADD_CLR_EN is
// defined, clr is also driven.
module tb_add_accum;

`ifdef ADD_CLR_EN
  localparam bit HAS_CLR = 1'b1;
`else
  localparam bit HAS_CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_drv;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;

  logic        in_ready4, out_valid4;
  logic [10:0] c4;
  logic        in_ready1, out_valid1;
  logic [8:0]  c1;

  always #5 clk = ~clk;

  add_accum #(.WIDTH(8), .COUNT(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef ADD_CLR_EN
    .clr      (clr_drv),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready4),
    .a        (a),
    .b        (b),
    .out_valid(out_valid4),
    .out_ready(out_ready),
    .c        (c4)
  );

  add_accum #(.WIDTH(8), .COUNT(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef ADD_CLR_EN
    .clr      (clr_drv),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready1),
    .a        (a),
    .b        (b),
    .out_valid(out_valid1),
    .out_ready(out_ready),
    .c        (c1)
  );

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  // Reference model per instance. Index 0 is COUNT=4 and index 1 is COUNT=1.
  bit exp_hold[2];
  int beats[2];
  int run[2];
  int exp_c[2];
  int q4[$];
  int q1[$];

  function automatic int frame_len(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic bit clr_active();
    return HAS_CLR && (clr_drv == 1'b1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // One rising edge of the reference model, computed from the inputs that
  // were applied for that edge.
  task automatic modelEdge(input int i);
    if (!rst_n || clr_active()) begin
      if (exp_hold[i]) begin
        if (i == 0 && q4.size() > 0) void'(q4.pop_front());
        if (i == 1 && q1.size() > 0) void'(q1.pop_front());
      end
      exp_hold[i] = 1'b0;
      beats[i]    = 0;
      run[i]      = 0;
      exp_c[i]    = 0;
    end else if (exp_hold[i]) begin
      if (out_ready) exp_hold[i] = 1'b0;
    end else if (in_valid) begin
      run[i]   = run[i] + int'(a) + int'(b);
      exp_c[i] = run[i];
      beats[i] = beats[i] + 1;
      if (beats[i] == frame_len(i)) begin
        if (i == 0) q4.push_back(run[i]);
        else        q1.push_back(run[i]);
        exp_hold[i] = 1'b1;
        beats[i]    = 0;
        run[i]      = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic v,
                               input logic ordy, input logic rn, input logic cl);
    a         = av;
    b         = bv;
    in_valid  = v;
    out_ready = ordy;
    rst_n     = rn;
    clr_drv   = cl;
    @(posedge clk);
    modelEdge(0);
    modelEdge(1);
    #1;
  endtask

  task automatic checkInst(input int i, input logic ov, input logic ir, input logic [31:0] cv);
    int front;
    bit have;
    checkOutput($sformatf("out_valid[%0d]", i), {31'b0, ov}, {31'b0, exp_hold[i]});
    checkOutput($sformatf("in_ready[%0d]", i), {31'b0, ir}, {31'b0, !exp_hold[i]});
    checkOutput($sformatf("c_tracking[%0d]", i), cv, exp_c[i]);
    if (exp_hold[i]) begin
      have  = (i == 0) ? (q4.size() > 0) : (q1.size() > 0);
      front = 0;
      if (have) front = (i == 0) ? q4[0] : q1[0];
      total++;
      if (!have) begin
        bad++;
        $display("[TB] FAIL scoreboard_empty[%0d] actual=%0d required=queued_sum at %0t", i, cv, $time);
      end else begin
        if (cv !== front) begin
          bad++;
          $display("[TB] FAIL frame_sum[%0d] actual=%0d required=%0d at %0t", i, cv, front, $time);
        end
        if (out_ready && rst_n && !clr_active()) begin
          if (i == 0) void'(q4.pop_front());
          else        void'(q1.pop_front());
        end
      end
    end
  endtask

  // Monitor: outputs are registered, so checking mid-cycle on the falling edge
  // is safe.
  always @(negedge clk) begin
    if (started) begin
      checkInst(0, out_valid4, in_ready4, 32'(c4));
      checkInst(1, out_valid1, in_ready1, 32'(c1));
    end
  end

  initial begin
    a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0; clr_drv = 1'b0;

    // Reset for two edges.
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    started = 1'b1;
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Basic frame. The COUNT=4 instance expects 514.
    applyStimulus(8'd1,   8'd0,   1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd0,   8'd1,   1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd1,   8'd1,   1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd255, 8'd255, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd0,   8'd0,   1'b0, 1'b1, 1'b1, 1'b0);

    // Maximum frame (2040), then a frame of zeros.
    for (int k = 0; k < 4; k++) applyStimulus(8'd255, 8'd255, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Backpressure: hold the sum for five cycles, then release it.
    for (int k = 0; k < 4; k++) applyStimulus(8'd10, 8'd20, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(8'd7, 8'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'd7, 8'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset mid-frame, then four (1,1) beats. The COUNT=4 instance expects 8.
    applyStimulus(8'd5, 8'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd5, 8'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(8'd1, 8'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // clr together with a beat drops that beat. The COUNT=4 instance then
    // expects 16.
    if (HAS_CLR) begin
      applyStimulus(8'd3, 8'd4, 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'd1, 8'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'd1, 8'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'd1, 8'd1, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) applyStimulus(8'd2, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    end

    // Random traffic with occasional reset and clr.
    for (int k = 0; k < 2000; k++) begin
      applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60),
                    ($urandom_range(0, 99) >= 2),
                    HAS_CLR && ($urandom_range(0, 99) < 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_accum.md
# add_accum

Parametrised, registered successor to the team's 1-bit adder: each accepted beat adds two `WIDTH`-bit unsigned operands, and `COUNT` consecutive beats are accumulated into one frame sum. The finished sum is presented on a valid/ready output and held until it is taken. The output is sized so that no frame can overflow. It sits between an operand source and a consumer, with valid/ready handshakes on both sides.

## Interface

- `WIDTH`, default 8: operand width in bits, ≥1.
- `COUNT`, default 4: beats per frame, ≥1.
- `OUT_W`, derived as `WIDTH+1+$clog2(COUNT)`: width of the sum. Not overridable.
- `clk` input 1: the single clock. All state changes on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: an operand beat is present.
- `in_ready` output 1: the block accepts a beat this cycle.
- `a` input `WIDTH`: operand A, unsigned.
- `b` input `WIDTH`: operand B, unsigned.
- `out_valid` output 1: the frame sum is present on `c`.
- `out_ready` input 1: the consumer takes the sum this cycle.
- `c` output `OUT_W`: the frame sum, unsigned.
- `clr` input 1: synchronous frame abort. Present only with `ADD_CLR_EN`.

## Operation

- **States:**
  - `ACC`: `in_ready`=1, `out_valid`=0.
  - `HOLD`: `in_ready`=0, `out_valid`=1.
- **Beat counter `cnt`:** range 0..`COUNT`-1.
- **Accepted beat:** `in_valid`&&`in_ready` in `ACC`.
  - `acc <= (cnt==0 ? 0 : acc) + a + b`.
  - Arithmetic is zero-extended to `OUT_W` and never wraps. The maximum is `COUNT*(2^(WIDTH+1)-2)`.
- **`ACC` transitions:**
  - Accepted beat with `cnt`<`COUNT`-1: `cnt++`, stay in `ACC`.
  - Accepted beat with `cnt`==`COUNT`-1: `cnt`<=0, go to `HOLD`.
  - No beat: state, `cnt` and `acc` are unchanged.
- **`HOLD` transitions:**
  - `c` is driven from `acc` and stays stable while `out_valid`=1.
  - `out_ready`=1: go to `ACC`.
  - `out_ready`=0: stay in `HOLD`. Input is back-pressured.
- **Boundary cases:**
  - `c` is not cleared on return to `ACC`. It keeps the last sum until the first beat of the next frame overwrites `acc`. Consumers must qualify `c` with `out_valid`.
  - `COUNT`=1: every accepted beat completes a frame, and `OUT_W`=`WIDTH`+1.
  - `in_valid` during `HOLD` is ignored, because `in_ready`=0. The source must hold its beat until it is accepted.
  - No same-cycle bypass: the output handshake in `HOLD` and the next input acceptance never occur in the same cycle.
- **Reset:** `rst_n`=0 at an edge gives state `ACC`, `cnt`=0, `acc`=0. This holds at any point, including mid-frame or in `HOLD`.
  - Outputs after reset: `in_ready`=1, `out_valid`=0, `c`=0.
  - Partial frames are discarded.

## Timing

- **Input acceptance:** one beat per cycle while in `ACC`.
- **Latency:** `out_valid` rises on the edge that accepts the final beat. The sum is therefore visible in the cycle after that beat is accepted.
- **Throughput:** minimum frame period is `COUNT`+1 cycles. That is `COUNT` beats plus 1 hold cycle, with `out_ready` held high.
- **Registered outputs:** all outputs are functions of registered state only. There is no combinational path from `in_valid`, `out_ready`, `a` or `b` to any output.
- **Priority, highest first:**
  1. `rst_n`
  2. `clr`
  3. Handshakes

## Configuration

- **Macro:** `ADD_CLR_EN`.
- **Defined:**
  - The `clr` port exists.
  - `clr`=1 at an edge, with `rst_n`=1, gives `acc`=0, `cnt`=0 and state `ACC`, from any state.
  - In that cycle a beat is not accepted, even if `in_valid`=1, and a pending sum is dropped without handshake.
- **Undefined:** there is no `clr` port, and the only way to abort a frame is `rst_n`.

## Test plan

All scenarios use `WIDTH`=8 and `COUNT`=4 unless noted, so `OUT_W`=11.

1. **Reset:** hold `rst_n`=0 for 2 edges, then release. Required: `in_ready`=1, `out_valid`=0, `c`=0.
2. **Basic frame:** beats (1,0), (0,1), (1,1), (255,255) on consecutive cycles with `out_ready`=1. Required: `out_valid`=1 for exactly one cycle, with `c`=514 (0x202), one cycle after the 4th beat.
3. **Maximum frame:** four beats of (255,255). Required: `c`=2040 (0x7F8) with no wrap. The next frame of four (0,0) beats gives `c`=0.
4. **Backpressure:** complete a frame with `out_ready`=0 for 5 cycles. Required: `c` stable, `out_valid`=1 and `in_ready`=0 throughout. Then `out_ready`=1 for one cycle, after which `in_ready`=1 on the next cycle.
5. **Reset mid-frame:** after 2 beats, pulse `rst_n`=0 for one edge, then send four (1,1) beats. Required: `c`=8.
6. **`COUNT`=1 instance, with `ADD_CLR_EN`:**
   - Beat (3,4). Required: `c`=7 one cycle later.
   - Then 2 beats of (1,1), followed by `clr` together with `in_valid`. Required: that beat is dropped.
   - On the `COUNT`=4 instance, the same sequence followed by four (2,2) beats gives `c`=16.
